// File: rtl/bp_pht_sched_if.sv
// bp_pht_sched_if: PHT update/clear scheduler bus
// master drives the requests (pipeline side), slave is the scheduler.
interface bp_pht_sched_if #(parameter int k = 10);
  logic         ClearReq;
  logic         PortEn;
  logic         UpdValid;
  logic [k-1:0] UpdIndex;
  logic [1:0]   UpdData;
  logic         UpdReady;
  logic         PHTWe;
  logic [k-1:0] PHTWa;
  logic [1:0]   PHTWd;
  logic         ClearBusy;
  logic         PredValid;
  modport master (output ClearReq, PortEn, UpdValid, UpdIndex, UpdData,
                  input UpdReady, PHTWe, PHTWa, PHTWd, ClearBusy, PredValid);
  modport slave (input ClearReq, PortEn, UpdValid, UpdIndex, UpdData,
                 output UpdReady, PHTWe, PHTWa, PHTWd, ClearBusy, PredValid);
endinterface

// File: rtl/bp_pht_sched.sv
// bp_pht_sched: schedules PHT clear sweeps and queued counter updates onto one write port
// Ports: clk, reset (sync, active-high); bus (slave): ClearReq/PortEn/UpdValid/UpdIndex/UpdData in,
// UpdReady/PHTWe/PHTWa/PHTWd/ClearBusy/PredValid out.
// Option: BP_PHT_SCHED_BYPASS_EN writes an update straight through when the queue is empty.
module bp_pht_sched #(
  parameter int k      = 10,
  parameter int QDEPTH = 2
) (
  input logic             clk,
  input logic             reset,
  bp_pht_sched_if.slave   bus
);
  localparam int AW = $clog2(QDEPTH);
  typedef enum logic {CLEAR, IDLE} state_e;
  state_e        state_q, state_d;
  logic [k-1:0]  cnt_q, cnt_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   occ_q, occ_d;
  logic [k+1:0]  mem_q [QDEPTH];
  logic          full, empty, ready, acc, byp, enq, deq;
  always_comb begin
    full  = occ_q == (AW+1)'(QDEPTH);
    empty = occ_q == '0;
    ready = ~reset & (state_q == CLEAR | ~full);
    // an update coinciding with ClearReq is dropped like any update during a clear
    acc   = bus.UpdValid & ready & ~bus.ClearReq;
`ifdef BP_PHT_SCHED_BYPASS_EN
    byp   = state_q == IDLE & empty & bus.PortEn & acc;
`else
    byp   = 1'b0;
`endif
    deq   = ~reset & state_q == IDLE & ~empty & bus.PortEn;
    enq   = state_q == IDLE & acc & ~byp;
    bus.UpdReady  = ready;
    bus.ClearBusy = reset | state_q == CLEAR;
    bus.PredValid = ~bus.ClearBusy;
    bus.PHTWe     = ~reset & (state_q == CLEAR ? bus.PortEn : deq | byp);
    bus.PHTWa     = state_q == CLEAR ? cnt_q : byp ? bus.UpdIndex : mem_q[rp_q][k+1:2];
    bus.PHTWd     = state_q == CLEAR ? 2'b01 : byp ? bus.UpdData : mem_q[rp_q][1:0];
    state_d = state_q;
    cnt_d   = cnt_q;
    wp_d    = wp_q + AW'(enq);
    rp_d    = rp_q + AW'(deq);
    occ_d   = occ_q + (AW+1)'(enq) - (AW+1)'(deq);
    if (state_q == CLEAR && bus.PortEn) begin
      cnt_d = cnt_q + k'(1);
      if (&cnt_q) state_d = IDLE;
    end
    if (bus.ClearReq) begin
      state_d = CLEAR;
      cnt_d   = '0;
      wp_d    = '0;
      rp_d    = '0;
      occ_d   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      occ_q   <= occ_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) mem_q[wp_q] <= {bus.UpdIndex, bus.UpdData};
  end
endmodule

// File: tb/tb_bp_pht_sched.sv
// tb_bp_pht_sched: vector table, directed corner sequences and random traffic against a queue model
module tb_bp_pht_sched;
  localparam int K  = 4;
  localparam int QD = 2;
  localparam int N  = 1 << K;
`ifdef BP_PHT_SCHED_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk, reset;
  bp_pht_sched_if #(.k(K)) bus ();
  bp_pht_sched #(.k(K), .QDEPTH(QD)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errs   = 0;
  bit m_clr = 1'b1;
  int m_ci  = 0;
  logic [K+1:0] m_q [$];
  logic obs_we, obs_rdy, obs_busy;
  logic [K-1:0] obs_wa;
  logic [1:0] obs_wd;
  typedef struct {
    bit r, c, p, v;
    logic [K-1:0] i;
    logic [1:0] d;
    bit we;
    logic [K-1:0] wa;
    logic [1:0] wd;
    bit rdy, busy;
  } vec_t;
  vec_t tv [8];
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic step(input bit r, input bit c, input bit p, input bit v,
                      input logic [K-1:0] i, input logic [1:0] d);
    bit e_we, e_rdy, e_busy, pop, push, bp;
    logic [K-1:0] e_wa;
    logic [1:0] e_wd;
    reset = r; bus.ClearReq = c; bus.PortEn = p; bus.UpdValid = v;
    bus.UpdIndex = i; bus.UpdData = d;
    @(negedge clk);
    obs_we = bus.PHTWe; obs_wa = bus.PHTWa; obs_wd = bus.PHTWd;
    obs_rdy = bus.UpdReady; obs_busy = bus.ClearBusy;
    pop = 0; push = 0; bp = 0; e_wa = '0; e_wd = '0;
    if (r) begin
      e_we = 0; e_rdy = 0; e_busy = 1;
    end else if (m_clr) begin
      e_we = p; e_wa = K'(m_ci); e_wd = 2'b01; e_rdy = 1; e_busy = 1;
    end else begin
      e_busy = 0;
      e_rdy = m_q.size() < QD;
      if (m_q.size() > 0 && p) begin
        e_we = 1; e_wa = m_q[0][K+1:2]; e_wd = m_q[0][1:0]; pop = 1;
      end else if (BYP && m_q.size() == 0 && p && v && !c) begin
        e_we = 1; e_wa = i; e_wd = d; bp = 1;
      end else e_we = 0;
      push = v && e_rdy && !c && !bp;
    end
    chk("PHTWe", obs_we, e_we);
    if (e_we) begin
      chk("PHTWa", obs_wa, e_wa);
      chk("PHTWd", obs_wd, e_wd);
    end
    chk("UpdReady", obs_rdy, e_rdy);
    chk("ClearBusy", obs_busy, e_busy);
    chk("PredValid", bus.PredValid, !e_busy);
    if (r || c) begin
      m_clr = 1; m_ci = 0; m_q.delete();
    end else if (m_clr) begin
      if (p) begin
        if (m_ci == N - 1) m_clr = 0;
        m_ci = (m_ci + 1) % N;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back({i, d});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic go_idle();
    step(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < N; n++) step(0, 0, 1, 0, 0, 0);
  endtask
  initial begin
    int wr;
    bit hit;
    reset = 1; bus.ClearReq = 0; bus.PortEn = 0; bus.UpdValid = 0;
    bus.UpdIndex = '0; bus.UpdData = '0;
    tv[0] = '{1,0,1,1, 0,0, 0,0,0, 0,1};
    tv[1] = '{1,0,0,0, 0,0, 0,0,0, 0,1};
    tv[2] = '{0,0,1,0, 0,0, 1,0,1, 1,1};
    tv[3] = '{0,0,0,0, 0,0, 0,0,0, 1,1};
    tv[4] = '{0,0,1,1, 9,3, 1,1,1, 1,1};
    tv[5] = '{0,1,1,0, 0,0, 1,2,1, 1,1};
    tv[6] = '{0,0,1,0, 0,0, 1,0,1, 1,1};
    tv[7] = '{0,0,1,0, 0,0, 1,1,1, 1,1};
    @(posedge clk); #1;
    for (int n = 0; n < 8; n++) begin
      step(tv[n].r, tv[n].c, tv[n].p, tv[n].v, tv[n].i, tv[n].d);
      chk($sformatf("tv%0d_we", n), obs_we, tv[n].we);
      if (tv[n].we) begin
        chk($sformatf("tv%0d_wa", n), obs_wa, tv[n].wa);
        chk($sformatf("tv%0d_wd", n), obs_wd, tv[n].wd);
      end
      chk($sformatf("tv%0d_rdy", n), obs_rdy, tv[n].rdy);
      chk($sformatf("tv%0d_busy", n), obs_busy, tv[n].busy);
    end
    step(1, 0, 1, 0, 0, 0);
    wr = 0;
    for (int n = 0; n < N; n++) begin
      step(0, 0, 1, 0, 0, 0);
      if (obs_we && obs_wa == K'(n) && obs_wd == 2'b01) wr++;
    end
    chk("full_clear_writes", wr, N);
    step(0, 0, 1, 1, 5, 3);
    chk("upd5_same_cycle_we", obs_we, BYP);
    step(0, 0, 1, 0, 0, 0);
    chk("upd5_next_cycle_we", obs_we, !BYP);
    step(0, 0, 0, 1, 1, 2);
    step(0, 0, 0, 1, 2, 2);
    step(0, 0, 0, 1, 3, 2);
    chk("full_ready", obs_rdy, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("drain_first", obs_wa, 1);
    step(0, 0, 1, 1, 3, 2);
    chk("drain_second", obs_wa, 2);
    step(0, 0, 1, 0, 0, 0);
    chk("drain_third", obs_wa, 3);
    step(0, 0, 0, 1, 7, 3);
    step(0, 0, 0, 1, 8, 3);
    step(0, 1, 0, 0, 0, 0);
    hit = 0;
    for (int n = 0; n < N; n++) begin
      step(0, 0, 1, 0, 0, 0);
      if (!obs_we || obs_wd != 2'b01 || obs_wa != K'(n)) hit = 1;
    end
    for (int n = 0; n < 3; n++) begin
      step(0, 0, 1, 0, 0, 0);
      if (obs_we) hit = 1;
    end
    chk("flushed_queue_not_written", hit, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 9; n++) step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("restart_at9_wa", obs_wa, 9);
    wr = 0;
    for (int n = 0; n < N; n++) begin
      step(0, 0, 1, 0, 0, 0);
      if (obs_we && obs_wa == K'(n)) wr++;
    end
    chk("restart_writes", wr, N);
    chk("restart_idle", bus.ClearBusy, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) step(0, 0, 1, 0, 0, 0);
    for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("hold_resume_wa", obs_wa, 3);
    go_idle();
    for (int n = 0; n < 3000; n++)
      step($urandom_range(199) == 0, $urandom_range(59) == 0, $urandom_range(3) != 0,
           $urandom_range(1) == 1, K'($urandom), 2'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
